pipeline_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core. It generates the 6-bit `stall` vector consumed by PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Stall vector bit map: [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB.
- It also redirects the PC on exceptions and ERET.
- It sequences recovery when a redirect lands while an AXI-Lite instruction fetch is still outstanding: the stale fetch response is discarded and PC/IF are held until the bus drains.
- It keeps a stall-cycle performance counter.

---
 rtl/pipeline_ctrl_pkg.sv | 28 ++
 rtl/pipeline_stall_prio.sv | 28 ++
 rtl/pipeline_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencer: stall vector
// encodings, redirect defaults and FSM state encoding.
package pipeline_ctrl_pkg;

  // Stall vector bit map: [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  // Per-bit hold levels and reset polarity.
  localparam logic STOP       = 1'b1;
  localparam logic NOT_STOP   = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  // Redirect defaults.
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
  localparam logic [31:0] ERET_CODE_DEFAULT  = 32'h0000_000E;

  // RUN: normal sequencing. DRAIN: a stale instruction fetch is still in
  // flight after a redirect and must be swallowed before IF resumes.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } ctrl_state_e;

endpackage : pipeline_ctrl_pkg

// File: rtl/pipeline_stall_prio.sv
// Priority encoder from per-stage stall requests to the 6-bit hold vector.
// The deepest requesting stage wins and freezes everything upstream of it.
module pipeline_stall_prio
  import pipeline_ctrl_pkg::*;
(
  input  logic       stallreq_if,
  input  logic       stallreq_id,
  input  logic       stallreq_ex,
  input  logic       stallreq_mem,
  output logic [5:0] stall_vec
);

  // Highest stage wins; lower requests are subsumed by the longer vector.
  always_comb begin
    if (stallreq_mem) begin
      stall_vec = STALL_MEM;
    end else if (stallreq_ex) begin
      stall_vec = STALL_EX;
    end else if (stallreq_id) begin
      stall_vec = STALL_ID;
    end else if (stallreq_if) begin
      stall_vec = STALL_IF;
    end else begin
      stall_vec = STALL_NONE;
    end
  end

endmodule : pipeline_stall_prio

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: stall vector generation, exception/ERET
// redirect, stale-fetch drain after a redirect, and a stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEFAULT,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype,
  input  logic [31:0]      cp0_epc,
  input  logic             if_busy,
  input  logic             if_resp_valid,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             discard_if,
  output logic [CNT_W-1:0] stall_cycles
);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [5:0]       prio_vec;
  logic             prio_if_req;
  logic             exc_valid;

  // While draining, IF is held regardless of its own request, so the
  // encoder only sees the fetch request in RUN.
  assign prio_if_req = stallreq_if & (state_q == ST_RUN);
  assign exc_valid   = (excepttype != 32'h0);

  pipeline_stall_prio u_prio (
    .stallreq_if  (prio_if_req),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .stall_vec    (prio_vec)
  );

  // Next state and combinational outputs; exception overrides all stalls.
  always_comb begin
    // NOTE: every output and next-state gets a default first, so no path
    // through the if/case tree can leave a value unassigned and infer a latch.
    state_d    = state_q;
    stall      = STALL_NONE;
    flush      = NOT_STOP;
    new_pc     = 32'h0;
    discard_if = 1'b0;

    if (rst == RST_ENABLE) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (exc_valid) begin
            // Stale data arriving right now is dropped in place; a fetch
            // still outstanding needs the DRAIN state to catch it later.
            discard_if = if_resp_valid;
            if (if_busy && !if_resp_valid) begin
              state_d = ST_DRAIN;
            end
          end else begin
            stall = prio_vec;
          end
        end
        ST_DRAIN: begin
          discard_if = 1'b1;
          if (exc_valid) begin
            if (if_resp_valid) begin
              state_d = ST_RUN;
            end
          end else begin
            stall = STALL_IF | prio_vec;
            if (if_resp_valid || !if_busy) begin
              state_d = ST_RUN;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase

      if (exc_valid) begin
        flush  = STOP;
        new_pc = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
      end
    end
  end

  // Count every non-reset cycle that drives a nonzero stall; wraps freely.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall != STALL_NONE) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (rst == RST_ENABLE) begin
      state_q        <= ST_RUN;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_pipeline_ctrl;

  localparam logic [31:0] EXC_VEC  = 32'hBFC0_0380;
  localparam logic [31:0] ERET     = 32'h0000_000E;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype, cp0_epc;
  logic        if_busy, if_resp_valid;

  logic [5:0]  stall, stall_s;
  logic        flush, flush_s;
  logic [31:0] new_pc, new_pc_s;
  logic        discard_if, discard_if_s;
  logic [31:0] stall_cycles;
  logic [2:0]  stall_cycles_s;

  int checks   = 0;
  int failures = 0;

  // Model state: whether a stale fetch is being drained, and the counters.
  bit          m_drain;
  logic [31:0] m_cnt;
  logic [2:0]  m_cnt_s;

  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_new_pc;
  logic        e_discard;

  always #5 clk = ~clk;

  pipeline_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excepttype    (excepttype),
    .cp0_epc       (cp0_epc),
    .if_busy       (if_busy),
    .if_resp_valid (if_resp_valid),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .discard_if    (discard_if),
    .stall_cycles  (stall_cycles)
  );

  // Narrow-counter instance so modulo wrap is reachable in a short run.
  pipeline_ctrl #(.CNT_W(3)) u_dut_small (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excepttype    (excepttype),
    .cp0_epc       (cp0_epc),
    .if_busy       (if_busy),
    .if_resp_valid (if_resp_valid),
    .stall         (stall_s),
    .flush         (flush_s),
    .new_pc        (new_pc_s),
    .discard_if    (discard_if_s),
    .stall_cycles  (stall_cycles_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs from the rules: the deepest requesting stage k
  // (IF=1..MEM=4) holds the lowest k+1 bits; drain adds PC/IF hold.
  task automatic model_outputs();
    int lvl;
    e_stall = 6'd0; e_flush = 1'b0; e_new_pc = 32'd0; e_discard = 1'b0;
    if (rst) return;
    if (excepttype != 0) begin
      e_flush   = 1'b1;
      e_new_pc  = (excepttype == ERET) ? cp0_epc : EXC_VEC;
      e_discard = m_drain || if_resp_valid;
    end else begin
      lvl = stallreq_mem ? 4 : stallreq_ex ? 3 : stallreq_id ? 2 :
            (stallreq_if && !m_drain) ? 1 : 0;
      if (lvl != 0) e_stall = 6'((1 << (lvl + 1)) - 1);
      if (m_drain) e_stall = e_stall | 6'd3;
      e_discard = m_drain;
    end
  endtask

  task automatic model_advance();
    if (rst) begin
      m_drain = 1'b0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      if (excepttype != 0) m_drain = m_drain ? !if_resp_valid : (if_busy && !if_resp_valid);
      else if (m_drain)    m_drain = if_busy && !if_resp_valid;
      if (e_stall != 0) begin
        m_cnt   = m_cnt + 1;
        m_cnt_s = m_cnt_s + 1;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rise.
  task automatic cycle();
    @(negedge clk);
    model_outputs();
    check("stall",        64'(stall),          64'(e_stall));
    check("flush",        64'(flush),          64'(e_flush));
    check("new_pc",       64'(new_pc),         64'(e_new_pc));
    check("discard_if",   64'(discard_if),     64'(e_discard));
    check("stall_cycles", 64'(stall_cycles),   64'(m_cnt));
    check("small_stall",  64'(stall_s),        64'(e_stall));
    check("small_count",  64'(stall_cycles_s), 64'(m_cnt_s));
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle();
    rst = 0; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excepttype = 0; cp0_epc = 0; if_busy = 0; if_resp_valid = 0;
  endtask

  initial begin
    logic [31:0] c0;
    m_drain = 0; m_cnt = 0; m_cnt_s = 0;
    idle();

    // Reset.
    rst = 1; cycle(); cycle(); rst = 0;

    // Priority: ID+EX together, then release.
    stallreq_id = 1; stallreq_ex = 1; cycle();
    stallreq_id = 0; stallreq_ex = 0; cycle();

    // Exception beats a MEM stall; then ERET to EPC.
    excepttype = 32'h1; stallreq_mem = 1; cycle();
    stallreq_mem = 0; excepttype = ERET; cp0_epc = 32'h8000_1234; cycle();
    idle(); cycle();

    // Drain: redirect with fetch outstanding, response after 3 cycles.
    excepttype = 32'h4; if_busy = 1; cycle();
    excepttype = 0; cycle();
    stallreq_ex = 1; cycle();
    stallreq_ex = 0; cycle();
    if_resp_valid = 1; cycle();
    if_resp_valid = 0; if_busy = 0; cycle();

    // Exception with stale data arriving the same cycle stays in RUN.
    excepttype = 32'h8; if_busy = 1; if_resp_valid = 1; cycle();
    idle(); cycle();

    // Counter: 5 IF stall cycles then one flush cycle add exactly 5.
    c0 = stall_cycles;
    stallreq_if = 1;
    repeat (5) cycle();
    stallreq_if = 0; excepttype = 32'h1; cycle();
    excepttype = 0;
    check("counter_delta", 64'(stall_cycles - c0), 64'd5);

    // Reset mid-drain, then a new fetch proceeds unstalled.
    excepttype = 32'h2; if_busy = 1; cycle();
    excepttype = 0; cycle();
    rst = 1; cycle();
    rst = 0; if_busy = 1; cycle();
    check("post_reset_stall", 64'(stall), 64'd0);
    idle(); cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst          = ($urandom % 64) == 0;
      stallreq_if  = ($urandom % 3) == 0;
      stallreq_id  = ($urandom % 5) == 0;
      stallreq_ex  = ($urandom % 6) == 0;
      stallreq_mem = ($urandom % 7) == 0;
      r = int'($urandom % 12);
      excepttype   = (r == 0) ? ERET : (r == 1) ? ($urandom | 32'h1) : 32'h0;
      cp0_epc      = $urandom;
      if_busy      = ($urandom % 3) != 0;
      if_resp_valid = if_busy && (($urandom % 4) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipeline_ctrl
